// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Pipeline stage register with one skid slot. in_ready comes
//            straight from a flop, so nothing downstream can ripple upstream.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_writereg,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_writereg,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [1:0]        occupancy
);

    localparam int c_PAY_W = 1 + RD_W + 2 * DATA_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 rdy_q, rdy_d;
    logic [c_PAY_W-1:0]   main_q, main_d;
    logic [c_PAY_W-1:0]   skid_q, skid_d;
    logic [c_PAY_W-1:0]   w_in_pay;
    logic                 w_accept;
    logic                 w_deliver;

    assign w_in_pay  = {in_writereg, in_rd, in_alu_res, in_mem_data};
    // A beat offered during flush is squashed, so it never loads storage.
    assign w_accept  = in_valid && rdy_q && !flush;
    assign w_deliver = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    state_d = ST_FULL;
                    main_d  = w_in_pay;
                end
            end
            ST_FULL: begin
                if (w_accept && w_deliver) begin
                    main_d = w_in_pay;
                end else if (w_accept) begin
                    state_d = ST_SKID;
                    skid_d  = w_in_pay;
                end else if (w_deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_deliver) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        rdy_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign in_ready     = rdy_q;
    assign out_valid    = (state_q != ST_EMPTY);
    assign occupancy    = (state_q == ST_SKID) ? 2'd2 :
                          (state_q == ST_FULL) ? 2'd1 : 2'd0;
    assign out_writereg = main_q[c_PAY_W-1] & out_valid;
    assign out_rd       = main_q[2*DATA_W +: RD_W];
    assign out_alu_res  = main_q[DATA_W +: DATA_W];
    assign out_mem_data = main_q[0 +: DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Self-checking bench: queue model of the stage plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_reg;

    localparam int DATA_W = 16;
    localparam int RD_W   = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_writereg;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_alu_res;
    logic [DATA_W-1:0] in_mem_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_writereg;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_alu_res;
    logic [DATA_W-1:0] out_mem_data;
    logic [1:0]        occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic              wr;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
    } beat_t;

    beat_t mq[$];

    pipe_skid_reg #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_writereg  (in_writereg),
        .in_rd        (in_rd),
        .in_alu_res   (in_alu_res),
        .in_mem_data  (in_mem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_writereg (out_writereg),
        .out_rd       (out_rd),
        .out_alu_res  (out_alu_res),
        .out_mem_data (out_mem_data),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two beats; head is what the stage presents.
    always @(posedge clk) begin
        bit acc, dlv;
        beat_t b;
        if (rst) begin
            mq.delete();
        end else begin
            dlv = (mq.size() > 0) && out_ready;
            acc = in_valid && (mq.size() < 2);
            b   = '{wr: in_writereg, rd: in_rd, alu: in_alu_res, mem: in_mem_data};
            if (flush) begin
                mq.delete();
            end else begin
                if (dlv) void'(mq.pop_front());
                if (acc) mq.push_back(b);
            end
        end
        #1;
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
        chk("m_in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
        chk("m_occupancy", {30'd0, occupancy}, mq.size());
        if (mq.size() > 0) begin
            chk("m_writereg", {31'd0, out_writereg}, {31'd0, mq[0].wr});
            chk("m_rd",       {28'd0, out_rd},       {28'd0, mq[0].rd});
            chk("m_alu",      {16'd0, out_alu_res},  {16'd0, mq[0].alu});
            chk("m_mem",      {16'd0, out_mem_data}, {16'd0, mq[0].mem});
        end else begin
            chk("m_writereg_idle", {31'd0, out_writereg}, 32'd0);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input logic wr, input logic [RD_W-1:0] rd,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
        in_valid    = 1'b1;
        in_writereg = wr;
        in_rd       = rd;
        in_alu_res  = alu;
        in_mem_data = mem;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid},    32'd0);
        chk({tag, "_in_ready"},  {31'd0, in_ready},     32'd1);
        chk({tag, "_occ"},       {30'd0, occupancy},    32'd0);
        chk({tag, "_wr"},        {31'd0, out_writereg}, 32'd0);
        chk({tag, "_rd"},        {28'd0, out_rd},       32'd0);
        chk({tag, "_alu"},       {16'd0, out_alu_res},  32'd0);
        chk({tag, "_mem"},       {16'd0, out_mem_data}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_writereg = 1'b0; in_rd = '0; in_alu_res = '0; in_mem_data = '0;
        repeat (2) step();
        rst = 1'b0;
        check_reset("reset");

        // Pass-through
        out_ready = 1'b1;
        offer(1'b1, 4'd3, 16'h1234, 16'hBEEF);
        step();
        in_valid = 1'b0;
        chk("pt_valid", {31'd0, out_valid},    32'd1);
        chk("pt_rd",    {28'd0, out_rd},       32'd3);
        chk("pt_alu",   {16'd0, out_alu_res},  32'h1234);
        chk("pt_mem",   {16'd0, out_mem_data}, 32'hBEEF);
        chk("pt_wr",    {31'd0, out_writereg}, 32'd1);
        step();

        // Backpressure into skid, then drain in order
        out_ready = 1'b0;
        offer(1'b0, 4'd1, 16'h0001, 16'h0000);
        step();
        offer(1'b0, 4'd2, 16'h0002, 16'h0000);
        step();
        in_valid = 1'b0;
        chk("bp_occ",   {30'd0, occupancy},   32'd2);
        chk("bp_rdy",   {31'd0, in_ready},    32'd0);
        chk("bp_alu",   {16'd0, out_alu_res}, 32'h0001);
        step();
        chk("bp_stable", {16'd0, out_alu_res}, 32'h0001);
        out_ready = 1'b1;
        #1;
        chk("bp_first", {16'd0, out_alu_res}, 32'h0001);
        step();
        chk("bp_second_v", {31'd0, out_valid},   32'd1);
        chk("bp_second",   {16'd0, out_alu_res}, 32'h0002);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 4'(i), 16'(i), 16'(i + 100));
            step();
            chk("st_alu", {16'd0, out_alu_res}, i);
            chk("st_rdy", {31'd0, in_ready},    32'd1);
        end
        in_valid = 1'b0;
        step();

        // Flush while in SKID with a beat offered
        out_ready = 1'b0;
        offer(1'b1, 4'd7, 16'h0011, 16'h0000);
        step();
        offer(1'b1, 4'd8, 16'h0022, 16'h0000);
        step();
        chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
        flush = 1'b1;
        offer(1'b1, 4'd9, 16'h0099, 16'h0099);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ",   {30'd0, occupancy},    32'd0);
        chk("fl_valid", {31'd0, out_valid},    32'd0);
        chk("fl_wr",    {31'd0, out_writereg}, 32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("fl_gone", {31'd0, out_valid}, 32'd0);
        end

        // rst + flush + in_valid together while FULL
        out_ready = 1'b0;
        offer(1'b1, 4'd5, 16'hAAAA, 16'h5555);
        step();
        chk("rf_full", {30'd0, occupancy}, 32'd1);
        rst = 1'b1; flush = 1'b1;
        offer(1'b1, 4'd6, 16'h7777, 16'h8888);
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check_reset("rstflush");

        // Randomized traffic; the model process checks every cycle
        for (int n = 0; n < 3000; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_writereg = 1'($urandom);
            in_rd       = 4'($urandom);
            in_alu_res  = 16'($urandom);
            in_mem_data = 16'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 31) == 0);
            rst         = ($urandom_range(0, 127) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
